// File: rtl/note_lane_ctrl_if.sv
// note_lane_ctrl_if -- control/event bundle for the note lane controller.
//   i_tick           1 ms strobe
//   i_start/pause/stop  one-cycle control pulses
//   i_period         ticks per one-position move
//   i_spawn/i_hit    per-lane spawn and button-press pulses
//   o_led            lane k at [k*LEN +: LEN], bit LEN-1 is the target
//   o_is_target      per-lane target bit
//   o_hit/miss/bad   one-cycle registered event pulses
//   o_hit_cnt/miss_cnt  saturating 16-bit totals
//   o_state          IDLE=0, RUN=1, PAUSE=2
// slave = the controller, master = whoever drives it.
interface note_lane_ctrl_if #(
    parameter int LANES   = 4,
    parameter int LEN     = 8,
    parameter int SPEED_W = 10
) ();
    logic                 i_tick;
    logic                 i_start;
    logic                 i_pause;
    logic                 i_stop;
    logic [SPEED_W-1:0]   i_period;
    logic [LANES-1:0]     i_spawn;
    logic [LANES-1:0]     i_hit;
    logic [LANES*LEN-1:0] o_led;
    logic [LANES-1:0]     o_is_target;
    logic [LANES-1:0]     o_hit;
    logic [LANES-1:0]     o_miss;
    logic [LANES-1:0]     o_bad;
    logic [15:0]          o_hit_cnt;
    logic [15:0]          o_miss_cnt;
    logic [1:0]           o_state;

    modport master (
        output i_tick, i_start, i_pause, i_stop, i_period, i_spawn, i_hit,
        input  o_led, o_is_target, o_hit, o_miss, o_bad, o_hit_cnt, o_miss_cnt, o_state
    );

    modport slave (
        input  i_tick, i_start, i_pause, i_stop, i_period, i_spawn, i_hit,
        output o_led, o_is_target, o_hit, o_miss, o_bad, o_hit_cnt, o_miss_cnt, o_state
    );
endinterface

// File: rtl/note_lane_ctrl.sv
// note_lane_ctrl -- rhythm-game note lanes. Notes spawn at bit 0 of each lane,
// march one position per move step toward the target bit LEN-1 and are either
// hit there or counted as a miss when they step off.
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         note_lane_ctrl_if.slave (controls, lane inputs, LEDs, events)
// note_lane is the per-lane shifter/scorer, replicated LANES times.

// note_lane -- one lane: LED shift register, pending spawn flag, event pulses.
//   clr       synchronous clear (stop), beats everything else
//   step      move strobe shared by all lanes
//   spawn_en  spawns accepted (RUN or PAUSE); hit_en  hits accepted (RUN)
//   hit_nx/miss_nx  next-cycle events, for the shared counters
module note_lane #(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           step,
    input  logic           spawn_en,
    input  logic           spawn,
    input  logic           hit_en,
    input  logic           hit,
    output logic [LEN-1:0] led,
    output logic           hit_nx,
    output logic           miss_nx,
    output logic           hit_ev,
    output logic           miss_ev,
    output logic           bad_ev
);
    logic pend, tgt, hit_q, bad_nx, fresh;

    // Hits look at the pre-shift target, so a hit on a step cycle wins over a miss.
    assign tgt     = led[LEN-1];
    assign hit_q   = hit_en & hit;
    assign hit_nx  = hit_q & tgt;
    assign bad_nx  = hit_q & ~tgt;
    assign miss_nx = step & tgt & ~hit_q;
    // A spawn on the step cycle itself goes straight into bit 0.
    assign fresh   = pend | (spawn_en & spawn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= '0;
            pend    <= 1'b0;
            hit_ev  <= 1'b0;
            miss_ev <= 1'b0;
            bad_ev  <= 1'b0;
        end else if (clr) begin
            led     <= '0;
            pend    <= 1'b0;
            hit_ev  <= 1'b0;
            miss_ev <= 1'b0;
            bad_ev  <= 1'b0;
        end else begin
            hit_ev  <= hit_nx;
            miss_ev <= miss_nx;
            bad_ev  <= bad_nx;
            if (step) begin
                // Old target bit falls off the end (already scored above).
                led  <= {led[LEN-2:0], fresh};
                pend <= 1'b0;
            end else begin
                if (hit_nx) led[LEN-1] <= 1'b0;
                pend <= fresh;
            end
        end
    end
endmodule

module note_lane_ctrl #(
    parameter int LANES   = 4,
    parameter int LEN     = 8,
    parameter int SPEED_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    note_lane_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    localparam logic [SPEED_W-1:0] ONE = SPEED_W'(1);

    state_t                    state;
    logic [SPEED_W-1:0]        cnt, per_q, per_in, per_cur;
    logic                      run, active, step;
    logic [LANES-1:0][LEN-1:0] led;
    logic [LANES-1:0]          hit_nx, miss_nx, hit_ev, miss_ev, bad_ev;
    logic [15:0]               hit_cnt, miss_cnt;

    function automatic logic [15:0] sat_add(input logic [15:0] base, input logic [LANES-1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base};
        for (int i = 0; i < LANES; i++) sum = sum + {16'd0, inc[i]};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign run    = (state == RUN);
    assign active = (state != IDLE);

    // Period is sampled at the start of each period (counter at 0); the latched
    // copy governs the rest of it, so i_period changes never stretch a move.
    assign per_in  = (bus.i_period == '0) ? ONE : bus.i_period;
    assign per_cur = (cnt == '0) ? per_in : per_q;
    assign step    = run & bus.i_tick & ~bus.i_stop & (cnt == per_cur - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            per_q    <= ONE;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (bus.i_stop) begin
            state    <= IDLE;
            cnt      <= '0;
            per_q    <= ONE;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (bus.i_start) state <= RUN;
                RUN:     if (bus.i_pause) state <= PAUSE;
                PAUSE:   if (bus.i_pause || bus.i_start) state <= RUN;
                default: state <= IDLE;
            endcase
            if (run && bus.i_tick) begin
                if (cnt == '0) per_q <= per_in;
                cnt <= step ? '0 : cnt + ONE;
            end
            hit_cnt  <= sat_add(hit_cnt, hit_nx);
            miss_cnt <= sat_add(miss_cnt, miss_nx);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        note_lane #(.LEN(LEN)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (bus.i_stop),
            .step     (step),
            .spawn_en (active),
            .spawn    (bus.i_spawn[k]),
            .hit_en   (run),
            .hit      (bus.i_hit[k]),
            .led      (led[k]),
            .hit_nx   (hit_nx[k]),
            .miss_nx  (miss_nx[k]),
            .hit_ev   (hit_ev[k]),
            .miss_ev  (miss_ev[k]),
            .bad_ev   (bad_ev[k])
        );
        assign bus.o_is_target[k] = led[k][LEN-1];
    end

    assign bus.o_led      = led;
    assign bus.o_hit      = hit_ev;
    assign bus.o_miss     = miss_ev;
    assign bus.o_bad      = bad_ev;
    assign bus.o_hit_cnt  = hit_cnt;
    assign bus.o_miss_cnt = miss_cnt;
    assign bus.o_state    = state;
endmodule

// File: doc/note_lane_ctrl.md
NOTE_LANE_CTRL -- requirements
Module: note_lane_ctrl

Interface
REQ-001 Parameter LANES, default 4, number of independent note lanes (1..8).
REQ-002 Parameter LEN, default 8, LED positions per lane (2..16); position LEN-1 is the target.
REQ-003 Parameter SPEED_W, default 10, width of step-period input.
REQ-004 Port clk input 1 system clock; single clock domain.
REQ-005 Port rst_n input 1 asynchronous active-low reset.
REQ-006 Port i_tick input 1 one-cycle 1 ms strobe.
REQ-007 Port i_start, i_pause, i_stop input 1 each, one-cycle control pulses.
REQ-008 Port i_period input SPEED_W, ticks per one-position move.
REQ-009 Port i_spawn input LANES, per-lane note spawn pulse.
REQ-010 Port i_hit input LANES, per-lane debounced button press pulse.
REQ-011 Port o_led output LANES*LEN, lane k at bits [k*LEN +: LEN], bit 0 entry, bit LEN-1 target.
REQ-012 Port o_is_target output LANES, lane k target bit.
REQ-013 Port o_hit, o_miss, o_bad output LANES each, one-cycle registered event pulses.
REQ-014 Port o_hit_cnt, o_miss_cnt output 16 each, saturating totals.
REQ-015 Port o_state output 2, encoding IDLE=0, RUN=1, PAUSE=2.

Function
REQ-016 FSM: IDLE -i_start-> RUN; RUN -i_pause-> PAUSE; PAUSE -i_pause or i_start-> RUN; any state -i_stop-> IDLE; i_stop has priority over all other controls in the same cycle.
REQ-017 Entering IDLE clears o_led, pending spawns, period counter, and both totals.
REQ-018 Period counter advances only on i_tick in RUN; holds its value in PAUSE; cleared in IDLE.
REQ-019 Move step is a one-cycle internal strobe, asserted on the i_tick for which the counter equals P-1; the counter then returns to 0.
REQ-020 P is i_period latched when the counter is 0; i_period=0 is treated as 1 (a move on every tick).
REQ-021 On a move step, every lane shifts toward the target: bit j takes bit j-1, and bit 0 takes pending[k] OR i_spawn[k].
REQ-022 i_spawn[k] in RUN or PAUSE sets pending[k]; pending[k] is cleared on the move step that consumes it; multiple spawns between steps merge into one note.
REQ-023 i_spawn is ignored in IDLE.
REQ-024 On a move step, any lane whose target bit is 1 and is not hit in that same cycle pulses o_miss[k] for one cycle, and o_miss_cnt increments by the number of lanes that missed.
REQ-025 i_hit[k] in RUN with target bit 1 clears that bit, pulses o_hit[k], and increments o_hit_cnt.
REQ-026 i_hit[k] in RUN with target bit 0 pulses o_bad[k] only; the counters are unchanged.
REQ-027 i_hit is ignored in IDLE and PAUSE.
REQ-028 Hit and move step in the same cycle: the hit is evaluated on the pre-shift target bit, so it counts as a hit with no miss, and the shift still occurs.
REQ-029 Hits in several lanes in one cycle all count; a counter increment is the popcount of qualifying lanes.
REQ-030 Counters saturate at 16'hFFFF.
REQ-031 o_led, o_is_target, and event pulses change only on clk edges; the event-pulse latency is 1 cycle after the causing input.
REQ-032 o_is_target[k] equals o_led[k*LEN+LEN-1] combinationally from registers.

Reset
REQ-033 rst_n low asynchronously forces state IDLE, o_led=0, pending=0, counter=0, all pulses 0, and both totals 0.
REQ-034 Reset asserted mid-RUN discards all notes without generating o_miss.
REQ-035 After rst_n deasserts, the block stays in IDLE until i_start.

Verification
REQ-036 Defaults, i_period=3, i_start, then i_spawn[0] pulse: the lane 0 note reaches bit 7 after 8 move steps (24 ticks), and o_miss[0] pulses on the 9th step.
REQ-037 Note at lane 1 target with i_hit[1] on the same cycle as a move step: o_hit[1]=1, o_miss[1]=0, o_hit_cnt=1.
REQ-038 i_hit[2] with an empty target: o_bad[2]=1 and both counters unchanged; i_hit in PAUSE gives no pulse at all.
REQ-039 i_pause mid-period, wait 50 ticks, then i_pause again: o_led is frozen throughout, and the next step occurs after the remaining ticks only.
REQ-040 Preload o_hit_cnt to 16'hFFFF via 65535 hits, then hit again: the count stays at 16'hFFFF.
REQ-041 rst_n pulled low with notes in all lanes: o_led=0, o_state=0, no o_miss pulses; i_stop in RUN gives the same result.
